// File: rtl/escape_pkg.sv
// Shared types and constants for the escape-depth engine and its squaring unit.
package escape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_OUTPUT
    } state_t;

    localparam logic MODE_MANDEL = 1'b0;
    localparam logic MODE_JULIA  = 1'b1;

    // |z|^2 escape bound: 4.0 expressed in the squared (2*FRAC) fixed-point scale.
    function automatic logic [127:0] threshold_sq(input int frac);
        return 128'd4 << (2 * frac);
    endfunction

endpackage

// File: rtl/escape_sq_unit.sv
// Squaring unit: zr^2, zi^2, 2*zr*zi and the escape flag, delayed by MUL_LAT register stages.
module escape_sq_unit
    import escape_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int MUL_LAT     = 2
) (
    input  logic                            i_clk,
    input  logic signed [WORD_LENGTH-1:0]   i_zr,
    input  logic signed [WORD_LENGTH-1:0]   i_zi,
    output logic signed [2*WORD_LENGTH-1:0] o_zr2,
    output logic signed [2*WORD_LENGTH-1:0] o_zi2,
    output logic signed [2*WORD_LENGTH-1:0] o_zrzi2,
    output logic                            o_escaped
);

    localparam int MAG_W = 2 * WORD_LENGTH + 1;
    localparam logic [MAG_W-1:0] THRESHOLD = MAG_W'(threshold_sq(FRAC));

    logic signed [2*WORD_LENGTH-1:0] w_zr2_p0;
    logic signed [2*WORD_LENGTH-1:0] w_zi2_p0;
    logic signed [2*WORD_LENGTH-1:0] w_zrzi2_p0;
    logic        [MAG_W-1:0]         w_mag_p0;
    logic                            w_escaped_p0;

    // Stage 0: full-width products; squares are non-negative so the magnitude sum needs one extra bit only.
    assign w_zr2_p0     = i_zr * i_zr;
    assign w_zi2_p0     = i_zi * i_zi;
    assign w_zrzi2_p0   = (i_zr * i_zi) <<< 1;
    assign w_mag_p0     = {1'b0, w_zr2_p0} + {1'b0, w_zi2_p0};
    assign w_escaped_p0 = (w_mag_p0 > THRESHOLD);

    generate
        if (MUL_LAT == 0) begin : g_comb
            assign o_zr2     = w_zr2_p0;
            assign o_zi2     = w_zi2_p0;
            assign o_zrzi2   = w_zrzi2_p0;
            assign o_escaped = w_escaped_p0;
        end else begin : g_pipe
            logic signed [2*WORD_LENGTH-1:0] r_zr2_p   [MUL_LAT];
            logic signed [2*WORD_LENGTH-1:0] r_zi2_p   [MUL_LAT];
            logic signed [2*WORD_LENGTH-1:0] r_zrzi2_p [MUL_LAT];
            logic                            r_esc_p   [MUL_LAT];

            // Stages 1..MUL_LAT: plain delay line, no reset on data.
            always_ff @(posedge i_clk) begin
                r_zr2_p[0]   <= w_zr2_p0;
                r_zi2_p[0]   <= w_zi2_p0;
                r_zrzi2_p[0] <= w_zrzi2_p0;
                r_esc_p[0]   <= w_escaped_p0;
                for (int k = 1; k < MUL_LAT; k++) begin
                    r_zr2_p[k]   <= r_zr2_p[k-1];
                    r_zi2_p[k]   <= r_zi2_p[k-1];
                    r_zrzi2_p[k] <= r_zrzi2_p[k-1];
                    r_esc_p[k]   <= r_esc_p[k-1];
                end
            end

            assign o_zr2     = r_zr2_p[MUL_LAT-1];
            assign o_zi2     = r_zi2_p[MUL_LAT-1];
            assign o_zrzi2   = r_zrzi2_p[MUL_LAT-1];
            assign o_escaped = r_esc_p[MUL_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/escape_engine.sv
// Escape-depth engine: iterates z <- z^2 + c for one pixel per job (Mandelbrot or Julia).
module escape_engine
    import escape_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int ITER_W      = 10,
    parameter int MUL_LAT     = 2,
    parameter int ID_W        = 16
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          mode,
    input  logic signed [WORD_LENGTH-1:0] re_p,
    input  logic signed [WORD_LENGTH-1:0] im_p,
    input  logic signed [WORD_LENGTH-1:0] re_k,
    input  logic signed [WORD_LENGTH-1:0] im_k,
    input  logic [ITER_W-1:0]             max_iter,
    input  logic [ID_W-1:0]               pix_id,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ITER_W-1:0]             out_depth,
    output logic                          out_escaped,
    output logic [ID_W-1:0]               out_id,
    output logic                          busy
);

    localparam logic [2:0] SETTLE_LAST = 3'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

    state_t r_state;
    state_t w_state_next;

    logic signed [WORD_LENGTH-1:0] r_zr, r_zi, r_cr, r_ci;
    logic [ITER_W-1:0]             r_depth;
    logic [ITER_W-1:0]             r_max_iter;
    logic [ID_W-1:0]               r_id;
    logic [2:0]                    r_wait;
    logic [ITER_W-1:0]             r_out_depth;
    logic                          r_out_escaped;
    logic [ID_W-1:0]               r_out_id;

    logic signed [2*WORD_LENGTH-1:0] w_zr2, w_zi2, w_zrzi2;
    logic                            w_escaped;
    logic                            w_done;
    logic signed [WORD_LENGTH-1:0]   w_re_sh, w_im_sh;
    logic signed [WORD_LENGTH-1:0]   w_zr_next, w_zi_next;

    escape_sq_unit #(
        .WORD_LENGTH (WORD_LENGTH),
        .FRAC        (FRAC),
        .MUL_LAT     (MUL_LAT)
    ) u_sq (
        .i_clk     (sysclk),
        .i_zr      (r_zr),
        .i_zi      (r_zi),
        .o_zr2     (w_zr2),
        .o_zi2     (w_zi2),
        .o_zrzi2   (w_zrzi2),
        .o_escaped (w_escaped)
    );

    // Next z: shift back to the coordinate scale, truncate with wrap, add c.
    assign w_re_sh   = WORD_LENGTH'((w_zr2 - w_zi2) >>> FRAC);
    assign w_im_sh   = WORD_LENGTH'(w_zrzi2 >>> FRAC);
    assign w_zr_next = w_re_sh + r_cr;
    assign w_zi_next = w_im_sh + r_ci;
    assign w_done    = w_escaped || (r_depth >= r_max_iter);

    always_ff @(posedge sysclk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // With a combinational squarer LOAD is folded into CHECK so each iteration is a single cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid) w_state_next = (MUL_LAT == 0) ? ST_CHECK : ST_LOAD;
            ST_LOAD:   w_state_next = (MUL_LAT <= 1) ? ST_CHECK : ST_SETTLE;
            ST_SETTLE: if (r_wait == SETTLE_LAST) w_state_next = ST_CHECK;
            ST_CHECK: begin
                if (w_done)            w_state_next = ST_OUTPUT;
                else if (MUL_LAT == 0) w_state_next = ST_CHECK;
                else                   w_state_next = ST_LOAD;
            end
            ST_OUTPUT: if (out_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == ST_IDLE) && !reset;
        out_valid   = (r_state == ST_OUTPUT);
        busy        = (r_state != ST_IDLE);
        out_depth   = r_out_depth;
        out_escaped = r_out_escaped;
        out_id      = r_out_id;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_zr          <= '0;
            r_zi          <= '0;
            r_cr          <= '0;
            r_ci          <= '0;
            r_depth       <= '0;
            r_max_iter    <= '0;
            r_id          <= '0;
            r_wait        <= '0;
            r_out_depth   <= '0;
            r_out_escaped <= 1'b0;
            r_out_id      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (mode == MODE_JULIA) begin
                            r_zr <= re_p;
                            r_zi <= im_p;
                            r_cr <= re_k;
                            r_ci <= im_k;
                        end else begin
                            r_zr <= '0;
                            r_zi <= '0;
                            r_cr <= re_p;
                            r_ci <= im_p;
                        end
                        r_depth    <= '0;
                        r_max_iter <= max_iter;
                        r_id       <= pix_id;
                    end
                end
                ST_LOAD:   r_wait <= '0;
                ST_SETTLE: r_wait <= r_wait + 3'd1;
                ST_CHECK: begin
                    if (w_done) begin
                        r_out_depth   <= r_depth;
                        r_out_escaped <= w_escaped;
                        r_out_id      <= r_id;
                    end else begin
                        r_zr    <= w_zr_next;
                        r_zi    <= w_zi_next;
                        r_depth <= r_depth + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_escape_engine.sv
// Bench for escape_engine: directed cases, random jobs against a plain iterative model, latency sweep.
module tb_escape_engine;

    localparam int WL      = 32;
    localparam int FRAC    = 28;
    localparam int IW      = 10;
    localparam int IDW     = 16;
    localparam int ML_MAIN = 2;
    localparam int SW_LAT [3] = '{0, 1, 4};
    localparam logic [64:0] THRESH = 65'd4 << (2 * FRAC);

    logic sysclk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic mode = 1'b0;
    logic signed [WL-1:0] re_p = '0, im_p = '0, re_k = '0, im_k = '0;
    logic [IW-1:0]  max_iter = '0;
    logic [IDW-1:0] pix_id = '0;
    logic           in_ready, out_valid, out_escaped, busy;
    logic [IW-1:0]  out_depth;
    logic [IDW-1:0] out_id;

    logic           sw_valid = 1'b0;
    logic           sw_ready = 1'b1;
    logic           s_in_ready [3];
    logic           s_out_valid [3];
    logic           s_esc [3];
    logic           s_busy [3];
    logic [IW-1:0]  s_depth [3];
    logic [IDW-1:0] s_id [3];

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    escape_engine #(.WORD_LENGTH(WL), .FRAC(FRAC), .ITER_W(IW), .MUL_LAT(ML_MAIN), .ID_W(IDW)) dut (
        .sysclk(sysclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .re_p(re_p), .im_p(im_p), .re_k(re_k), .im_k(im_k), .max_iter(max_iter), .pix_id(pix_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_depth(out_depth),
        .out_escaped(out_escaped), .out_id(out_id), .busy(busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        escape_engine #(.WORD_LENGTH(WL), .FRAC(FRAC), .ITER_W(IW), .MUL_LAT(SW_LAT[g]), .ID_W(IDW)) u_sw (
            .sysclk(sysclk), .reset(reset), .in_valid(sw_valid), .in_ready(s_in_ready[g]), .mode(mode),
            .re_p(re_p), .im_p(im_p), .re_k(re_k), .im_k(im_k), .max_iter(max_iter), .pix_id(pix_id),
            .out_valid(s_out_valid[g]), .out_ready(sw_ready), .out_depth(s_depth[g]),
            .out_escaped(s_esc[g]), .out_id(s_id[g]), .busy(s_busy[g])
        );
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Straight iteration of z <- z^2 + c with 64-bit products and 32-bit wrap on the result.
    function automatic void ref_escape(input bit md, input int rp, input int ip, input int rk,
                                       input int ik, input int mi, output int d, output bit e);
        int zr, zi, cr, ci;
        longint sr, si, pr;
        logic [64:0] mag;
        if (md) begin zr = rp; zi = ip; cr = rk; ci = ik; end
        else    begin zr = 0;  zi = 0;  cr = rp; ci = ip; end
        d = 0;
        e = 1'b0;
        for (int it = 0; it <= 2000; it++) begin
            sr  = longint'(zr) * longint'(zr);
            si  = longint'(zi) * longint'(zi);
            mag = 65'(sr) + 65'(si);
            e   = (mag > THRESH);
            if (e || d >= mi) break;
            pr = longint'(zr) * longint'(zi);
            pr = pr * 2;
            zr = int'((sr - si) >>> FRAC) + cr;
            zi = int'(pr >>> FRAC) + ci;
            d++;
        end
    endfunction

    function automatic int rnd_coord();
        return int'($urandom_range(32'h3FFF_FFFF, 0)) - 32'sh2000_0000;
    endfunction

    task automatic send_job(input bit md, input int rp, input int ip, input int rk, input int ik,
                            input int mi, input int id, output int t_acc);
        int n = 0;
        mode = md; re_p = rp; im_p = ip; re_k = rk; im_k = ik;
        max_iter = IW'(mi); pix_id = IDW'(id);
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin tick(); n++; end
        chk("accept_ready", in_ready, 1);
        tick();
        t_acc = cyc - 1;
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int t_acc, input int ed, input bit ee,
                              input int id, input int stall, input bit hold);
        int n = 0;
        int budget = (ed + 1) * (ML_MAIN + 1) + 20;
        while (!out_valid && n < budget) begin tick(); n++; end
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_lat"}, cyc - t_acc, 1 + (ed + 1) * (ML_MAIN + 1));
        chk({tag, "_depth"}, out_depth, ed);
        chk({tag, "_esc"}, out_escaped, ee);
        chk({tag, "_id"}, out_id, id);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "_hold_vld"}, out_valid, 1);
            chk({tag, "_hold_depth"}, out_depth, ed);
            chk({tag, "_hold_id"}, out_id, id);
            chk({tag, "_hold_inrdy"}, in_ready, 0);
        end
        if (!hold) begin
            out_ready = 1'b1;
            tick();
            chk({tag, "_drop"}, out_valid, 0);
        end
    endtask

    task automatic run_exp(input string tag, input bit md, input int rp, input int ip, input int rk,
                           input int ik, input int mi, input int id, input int ed, input bit ee,
                           input int stall);
        int t;
        out_ready = (stall == 0);
        send_job(md, rp, ip, rk, ik, mi, id, t);
        finish_job(tag, t, ed, ee, id, stall, 1'b0);
    endtask

    task automatic run_job(input string tag, input bit md, input int rp, input int ip, input int rk,
                           input int ik, input int mi, input int id, input int stall);
        int ed;
        bit ee;
        ref_escape(md, rp, ip, rk, ik, mi, ed, ee);
        run_exp(tag, md, rp, ip, rk, ik, mi, id, ed, ee, stall);
    endtask

    task automatic run_sweep();
        int ed, t_acc, n;
        bit ee;
        int first [3] = '{-1, -1, -1};
        logic [IW-1:0]  got_d [3];
        logic           got_e [3];
        logic [IDW-1:0] got_id [3];
        ref_escape(0, int'(32'hF400_0000), 26843546, 0, 0, 1023, ed, ee);
        mode = 1'b0; re_p = 32'hF400_0000; im_p = 26843546; re_k = '0; im_k = '0;
        max_iter = 10'd1023; pix_id = 16'h0BEE;
        for (int g = 0; g < 3; g++) chk($sformatf("sw%0d_inrdy", SW_LAT[g]), s_in_ready[g], 1);
        sw_valid = 1'b1;
        tick();
        t_acc = cyc - 1;
        sw_valid = 1'b0;
        n = 0;
        while (n < 8000 && (first[0] < 0 || first[1] < 0 || first[2] < 0)) begin
            for (int g = 0; g < 3; g++) begin
                if (first[g] < 0 && s_out_valid[g]) begin
                    first[g] = cyc; got_d[g] = s_depth[g]; got_e[g] = s_esc[g]; got_id[g] = s_id[g];
                end
            end
            if (first[0] < 0 || first[1] < 0 || first[2] < 0) begin tick(); n++; end
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("sw%0d_lat", SW_LAT[g]), first[g] - t_acc, 1 + (ed + 1) * (SW_LAT[g] + 1));
            chk($sformatf("sw%0d_depth", SW_LAT[g]), got_d[g], ed);
            chk($sformatf("sw%0d_esc", SW_LAT[g]), got_e[g], ee);
            chk($sformatf("sw%0d_id", SW_LAT[g]), got_id[g], 16'h0BEE);
        end
        repeat (3) tick();
        for (int g = 0; g < 3; g++) chk($sformatf("sw%0d_idle", SW_LAT[g]), s_busy[g], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, cnt;
        tick();
        tick();
        chk("rst_inrdy_low", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_inrdy", in_ready, 1);
        chk("rst_outvld", out_valid, 0);
        chk("rst_depth", out_depth, 0);
        chk("rst_esc", out_escaped, 0);
        chk("rst_id", out_id, 0);
        chk("rst_busy", busy, 0);

        run_exp("m_c0",  0, 0, 0, 0, 0, 10, 16'h0001, 10, 0, 0);
        run_exp("m_c2",  0, 32'h2000_0000, 0, 0, 0, 100, 16'h0002, 2, 1, 0);
        run_exp("m_c3",  0, 32'h3000_0000, 0, 0, 0, 100, 16'h0003, 1, 1, 0);
        run_exp("j_p1",  1, 32'h1000_0000, 0, 0, 0, 50, 16'h0004, 50, 0, 0);
        run_exp("j_p3",  1, 32'h3000_0000, 0, 0, 0, 50, 16'h0005, 0, 1, 0);
        run_exp("mi0",   0, 0, 0, 0, 0, 0, 16'h0006, 0, 0, 0);

        // Stalled result with a queued job that must wait for the handshake.
        out_ready = 1'b0;
        send_job(0, 32'h3000_0000, 0, 0, 0, 100, 16'h1234, t);
        finish_job("stall", t, 1, 1, 16'h1234, 20, 1'b1);
        mode = 1'b0; re_p = 32'h2000_0000; im_p = '0; max_iter = 10'd100; pix_id = 16'h0055;
        in_valid = 1'b1;
        tick();
        chk("ovl_inrdy", in_ready, 0);
        chk("ovl_vld", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("ovl_hs_vld", out_valid, 0);
        chk("ovl_hs_inrdy", in_ready, 1);
        chk("ovl_hs_busy", busy, 0);
        tick();
        t = cyc - 1;
        in_valid = 1'b0;
        chk("ovl_acc_busy", busy, 1);
        finish_job("ovl_job", t, 2, 1, 16'h0055, 0, 1'b0);

        // Reset in the middle of a long job.
        out_ready = 1'b1;
        send_job(0, 0, 0, 0, 0, 500, 16'h0007, t);
        tick();
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_inrdy", in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_post_inrdy", in_ready, 1);
        chk("mid_post_busy", busy, 0);
        cnt = 0;
        repeat (40) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("mid_no_result", cnt, 0);
        run_exp("post_rst", 0, 32'h3000_0000, 0, 0, 0, 100, 16'h0008, 1, 1, 0);

        for (int j = 0; j < 25; j++) begin
            run_job($sformatf("rnd%0d", j), 1'($urandom_range(1, 0)), rnd_coord(), rnd_coord(),
                    rnd_coord(), rnd_coord(), int'($urandom_range(60, 0)),
                    int'($urandom_range(16'hFFFF, 0)), int'($urandom_range(3, 0)));
        end

        run_sweep();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
